// File: rtl/pr_region_freeze_ctrl.sv
// Freeze/unfreeze sequencer for a partial-reconfiguration region: drains outstanding
// traffic, holds the region frozen, then pulses region reset before releasing it.
module pr_region_freeze_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned RESET_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       freeze_req,
  input  logic       unfreeze_req,
  input  logic       reset_req,
  input  logic       region_busy,
  output logic       freeze_status,
  output logic       unfreeze_status,
  output logic [1:0] illegal_req,
  output logic       region_freeze,
  output logic       region_reset
);

  localparam int unsigned DCW = 16;
  localparam int unsigned RCW = 8;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNFRZ    = 2'b01;
  localparam logic [1:0] ERR_BOTH     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [RCW-1:0] RESET_LAST = RCW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {RUN, DRAIN, FROZEN, URESET, UACK} state_t;

  state_t         state;
  state_t         state_nx_c;
  logic [DCW-1:0] drain_cnt;
  logic [RCW-1:0] rst_cnt;
  logic           both_c;
  logic           timeout_c;
  logic           keep_timeout_c;
  logic [1:0]     err_nx_c;

  // Next-state decode; both requests high blocks every transition.
  always_comb begin
    state_nx_c = state;
    timeout_c  = 1'b0;
    both_c     = freeze_req & unfreeze_req;
    case (state)
      RUN:    if (freeze_req && !unfreeze_req) state_nx_c = DRAIN;
      DRAIN: begin
        if (!unfreeze_req) begin
          if (!region_busy) begin
            state_nx_c = FROZEN;
          end else if (drain_cnt >= DRAIN_LAST) begin
            state_nx_c = FROZEN;
            timeout_c  = 1'b1;
          end
        end
      end
      FROZEN: if (unfreeze_req && !freeze_req) state_nx_c = URESET;
      URESET: if (!both_c && rst_cnt >= RESET_LAST) state_nx_c = UACK;
      UACK:   if (!unfreeze_req) state_nx_c = RUN;
      default: state_nx_c = RUN;
    endcase
  end

  // Error code: timeout is sticky until unfreeze starts or reset_req; others clear when idle.
  always_comb begin
    err_nx_c       = illegal_req;
    keep_timeout_c = (illegal_req == ERR_TIMEOUT) && !reset_req &&
                     !((state != URESET) && (state_nx_c == URESET));
    if (timeout_c || keep_timeout_c) begin
      err_nx_c = ERR_TIMEOUT;
    end else if (both_c) begin
      err_nx_c = ERR_BOTH;
    end else if (unfreeze_req && ((state == RUN) || (state == DRAIN))) begin
      err_nx_c = ERR_UNFRZ;
    end else if (!freeze_req && !unfreeze_req) begin
      err_nx_c = ERR_NONE;
    end else if (illegal_req == ERR_TIMEOUT) begin
      err_nx_c = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      drain_cnt       <= '0;
      rst_cnt         <= '0;
      freeze_status   <= 1'b0;
      unfreeze_status <= 1'b0;
      illegal_req     <= ERR_NONE;
      region_freeze   <= 1'b0;
      region_reset    <= 1'b0;
    end else begin
      state <= state_nx_c;

      if (state != DRAIN) begin
        drain_cnt <= '0;
      end else if (drain_cnt < DRAIN_LAST) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end

      if (state != URESET) begin
        rst_cnt <= '0;
      end else if (!both_c && rst_cnt < RESET_LAST) begin
        rst_cnt <= rst_cnt + RCW'(1);
      end

      freeze_status   <= (state_nx_c == FROZEN);
      unfreeze_status <= (state_nx_c == UACK);
      region_freeze   <= (state_nx_c == DRAIN) || (state_nx_c == FROZEN) ||
                         (state_nx_c == URESET);
      region_reset    <= reset_req || (state_nx_c == URESET);
      illegal_req     <= err_nx_c;
    end
  end

endmodule

// File: tb/tb_pr_region_freeze_ctrl.sv
// Directed bench for pr_region_freeze_ctrl; expected output words are queued with each
// stimulus step and checked one clock later.
module tb_pr_region_freeze_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       freeze_req;
  logic       unfreeze_req;
  logic       reset_req;
  logic       region_busy;
  logic       freeze_status;
  logic       unfreeze_status;
  logic [1:0] illegal_req;
  logic       region_freeze;
  logic       region_reset;

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  localparam logic [5:0] Z = 6'b000000;

  always #5 clk = ~clk;

  pr_region_freeze_ctrl #(
    .DRAIN_TIMEOUT(8),
    .RESET_CYCLES (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .freeze_req     (freeze_req),
    .unfreeze_req   (unfreeze_req),
    .reset_req      (reset_req),
    .region_busy    (region_busy),
    .freeze_status  (freeze_status),
    .unfreeze_status(unfreeze_status),
    .illegal_req    (illegal_req),
    .region_freeze  (region_freeze),
    .region_reset   (region_reset)
  );

  // Output word: {freeze_status, unfreeze_status, illegal_req, region_freeze, region_reset}
  function automatic logic [5:0] ex(input logic fs, input logic us, input logic [1:0] ill,
                                    input logic rf, input logic rr);
    return {fs, us, ill, rf, rr};
  endfunction

  task automatic check_out();
    logic [5:0] e;
    logic [5:0] obs;
    string      t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: observed no expected entry, expected one queued");
    end else begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {freeze_status, unfreeze_status, illegal_req, region_freeze, region_reset};
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
    end
  endtask

  task automatic step(input logic f, input logic u, input logic r, input logic b,
                      input logic [5:0] e, input string t);
    freeze_req   = f;
    unfreeze_req = u;
    reset_req    = r;
    region_busy  = b;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic expect_now(input logic [5:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    check_out();
  endtask

  initial begin
    reset_n      = 1'b0;
    freeze_req   = 1'b0;
    unfreeze_req = 1'b0;
    reset_req    = 1'b0;
    region_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_now(Z, "reset_state");
    reset_n = 1'b1;

    // Basic freeze with idle region
    step(1, 0, 0, 0, ex(0, 0, 2'b00, 1, 0), "drain_entry");
    step(1, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "frozen");
    step(1, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "frozen_hold");
    step(0, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "frozen_idle");

    // Unfreeze: 16 cycles of region reset then acknowledge
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, ex(0, 0, 2'b00, 1, 1), "ureset");
    step(0, 1, 0, 0, ex(0, 1, 2'b00, 0, 0), "uack");
    step(0, 1, 0, 0, ex(0, 1, 2'b00, 0, 0), "uack_hold");
    step(0, 0, 0, 0, Z, "back_to_run");

    // Conflicting requests and unfreeze while running
    step(1, 1, 0, 0, ex(0, 0, 2'b10, 0, 0), "both_run");
    step(1, 1, 0, 0, ex(0, 0, 2'b10, 0, 0), "both_run_hold");
    step(0, 0, 0, 0, Z, "both_clear");
    step(0, 1, 0, 0, ex(0, 0, 2'b01, 0, 0), "unfreeze_in_run");
    step(0, 1, 0, 0, ex(0, 0, 2'b01, 0, 0), "unfreeze_in_run_hold");
    step(0, 0, 0, 0, Z, "unfreeze_clear");
    step(0, 0, 1, 0, ex(0, 0, 2'b00, 0, 1), "reset_req_run");
    step(0, 0, 0, 0, Z, "reset_req_drop");

    // Drain timeout with region stuck busy; unfreeze attempt mid-drain
    for (int i = 0; i < 8; i++) begin
      if (i == 3)      step(0, 1, 0, 1, ex(0, 0, 2'b01, 1, 0), "unfreeze_in_drain");
      else if (i == 4) step(0, 0, 0, 1, ex(0, 0, 2'b00, 1, 0), "drain_err_clear");
      else             step(1, 0, 0, 1, ex(0, 0, 2'b00, 1, 0), "drain_busy");
    end
    step(1, 0, 0, 1, ex(1, 0, 2'b11, 1, 0), "drain_timeout");
    step(0, 0, 0, 1, ex(1, 0, 2'b11, 1, 0), "timeout_sticky");
    step(1, 1, 0, 1, ex(1, 0, 2'b11, 1, 0), "timeout_priority");
    step(0, 0, 1, 0, ex(1, 0, 2'b00, 1, 1), "reset_req_clears_timeout");
    step(0, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "frozen_after_reset_req");
    step(1, 1, 0, 0, ex(1, 0, 2'b10, 1, 0), "both_frozen");
    step(0, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "both_frozen_clear");

    // Asynchronous reset in the middle of the unfreeze reset pulse
    step(0, 1, 0, 0, ex(0, 0, 2'b00, 1, 1), "ureset_again");
    step(0, 1, 0, 0, ex(0, 0, 2'b00, 1, 1), "ureset_again_hold");
    reset_n = 1'b0;
    #1;
    expect_now(Z, "async_reset");
    @(posedge clk);
    #1;
    expect_now(Z, "async_reset_hold");
    reset_n      = 1'b1;
    unfreeze_req = 1'b0;
    step(0, 0, 0, 0, Z, "post_reset_run");
    step(1, 0, 0, 0, ex(0, 0, 2'b00, 1, 0), "post_reset_drain");
    step(1, 0, 0, 0, ex(1, 0, 2'b00, 1, 0), "post_reset_frozen");
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, ex(0, 0, 2'b00, 1, 1), "post_reset_ureset");
    step(0, 1, 0, 0, ex(0, 1, 2'b00, 0, 0), "post_reset_uack");

    // Held freeze_req re-freezes; timeout code clears on unfreeze entry
    step(1, 0, 0, 1, Z, "uack_to_run");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, ex(0, 0, 2'b00, 1, 0), "refreeze_drain");
    step(1, 0, 0, 1, ex(1, 0, 2'b11, 1, 0), "refreeze_timeout");
    step(0, 1, 0, 0, ex(0, 0, 2'b00, 1, 1), "timeout_clears_on_ureset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pr_region_freeze_ctrl.md
PR_REGION_FREEZE_CTRL -- requirements
Module: pr_region_freeze_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, 1024, max cycles spent in DRAIN waiting for region_busy low (range 1..65535).
REQ-002 Parameter RESET_CYCLES, 16, cycles region_reset is held during unfreeze (range 1..255).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 freeze_req  input  1  level request from PIO conduit to freeze the region.
REQ-006 unfreeze_req  input  1  level request from PIO conduit to unfreeze the region.
REQ-007 reset_req  input  1  level request from PIO conduit to hold the region in reset.
REQ-008 freeze_status  output  1  high while region is frozen.
REQ-009 unfreeze_status  output  1  high while unfreeze is complete and unfreeze_req is still high.
REQ-010 illegal_req  output  2  error code (00 none, 01 unfreeze while not frozen, 10 freeze and unfreeze together, 11 drain timeout).
REQ-011 region_busy  input  1  PR region has outstanding transactions.
REQ-012 region_freeze  output  1  gates PR region bridges; high blocks new transactions.
REQ-013 region_reset  output  1  active-high reset to the PR region.

Function
REQ-014 All outputs SHALL be registered; FSM states RUN, DRAIN, FROZEN, URESET, UACK.
REQ-015 RUN: freeze_req=1 and unfreeze_req=0 sampled -> DRAIN next edge; region_freeze=1 from that edge.
REQ-016 DRAIN: region_busy=0 sampled -> FROZEN next edge; the drain counter SHALL clear on DRAIN entry and increment each DRAIN cycle.
REQ-017 DRAIN: counter reaching DRAIN_TIMEOUT with region_busy=1 -> FROZEN anyway, illegal_req=11.
REQ-018 freeze_status SHALL be 1 exactly while the state is FROZEN; region_freeze SHALL be 1 in DRAIN, FROZEN and URESET.
REQ-019 FROZEN: the state SHALL persist whatever the value of freeze_req; unfreeze_req=1 and freeze_req=0 -> URESET next edge.
REQ-020 URESET: region_reset=1 for exactly RESET_CYCLES cycles, then UACK; region_freeze SHALL drop on UACK entry.
REQ-021 UACK: unfreeze_status=1; unfreeze_req=0 sampled -> RUN next edge, unfreeze_status=0.
REQ-022 freeze_req=1 and unfreeze_req=1 on the same cycle SHALL cause no state transition in any state and SHALL set illegal_req=10.
REQ-023 unfreeze_req=1 sampled in RUN or DRAIN SHALL set illegal_req=01 with no state change.
REQ-024 Codes 01 and 10 SHALL clear on the first cycle both requests are low; code 11 SHALL clear only on URESET entry or reset_req=1.
REQ-025 On simultaneous errors the priority SHALL be 11 > 10 > 01.
REQ-026 region_reset SHALL equal registered reset_req OR the URESET pulse (1-cycle latency); reset_req SHALL NOT change FSM state.
REQ-027 freeze_req held high in RUN after UACK SHALL start a new freeze (no edge detection).

Reset
REQ-028 reset_n low SHALL asynchronously force state RUN, counters 0, and all outputs 0 (illegal_req=00).
REQ-029 reset_n deassertion mid-DRAIN or mid-URESET SHALL resume in RUN with region_freeze=0 on the first clock.

Verification
REQ-030 RUN, region_busy=0, freeze_req=1 -> region_freeze=1 after 1 edge, freeze_status=1 after 2 edges.
REQ-031 region_busy=1 held, DRAIN_TIMEOUT=8, freeze_req=1 -> FROZEN after 9 edges, illegal_req=11.
REQ-032 FROZEN, freeze_req=0, unfreeze_req=1, RESET_CYCLES=16 -> region_reset high for 16 cycles, then unfreeze_status=1, region_freeze=0; drop unfreeze_req -> RUN, unfreeze_status=0.
REQ-033 RUN, freeze_req=unfreeze_req=1 -> illegal_req=10 and state unchanged; both low -> illegal_req=00.
REQ-034 RUN, unfreeze_req=1 -> illegal_req=01, region_freeze stays 0.
REQ-035 reset_n asserted during URESET -> all outputs 0 immediately; after release, freeze_req=1 runs a full freeze normally.
